// File: rtl/enet_pkg.sv
// Shared Ethernet MAC-control constants and the pause-frame parser state type.
package enet_pkg;

   localparam logic [15:0] ENET_TYPE_MAC_CTRL = 16'h8808;
   localparam logic [15:0] ENET_OPC_PAUSE     = 16'h0001;
   localparam logic [47:0] ENET_PAUSE_MCAST   = 48'h0180C2000001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DA,
      ST_SA,
      ST_TYPE,
      ST_OPC,
      ST_QUANTA,
      ST_WAIT_EOF
   } parse_state_t;

   // Byte idx (0 = first on the wire) of a 6-byte MAC address.
   function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
      logic [47:0] shifted;
      shifted = addr >> (6'd40 - {idx, 3'b000});
      return shifted[7:0];
   endfunction

   // Byte of a 2-byte field sent MSB first: sel 0 = high byte, 1 = low byte.
   function automatic logic [7:0] field_byte(input logic [15:0] field, input logic sel);
      return sel ? field[7:0] : field[15:8];
   endfunction

endpackage

// File: rtl/enet_pause_timer.sv
// Pause quanta down-counter: load overrides tick, saturates at zero.
module enet_pause_timer #(
   parameter int PAUSE_W = 16
) (
   input  logic               rx_clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [PAUSE_W-1:0] load_val,
   input  logic               tick,
   output logic [PAUSE_W-1:0] count,
   output logic               active
);

   // Load a fresh pause time, otherwise count down one quantum per tick.
   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign active = (count != '0);

endmodule

// File: rtl/enet_rx_pause_ctrl.sv
// Receive-side 802.3x pause frame detector and pause timer.
// Optional build macro ENET_RX_PAUSE_UNICAST_EN: also accept pause frames
// addressed to the station address {palr, paur_u16}.
//
// state       | meaning
// ST_IDLE     | no frame in progress, bytes without sof ignored
// ST_DA       | comparing destination address bytes 0..5
// ST_SA       | skipping source address bytes 0..5
// ST_TYPE     | checking length/type field against 0x8808
// ST_OPC      | checking MAC control opcode against 0x0001
// ST_QUANTA   | capturing pause quanta (MSB first)
// ST_WAIT_EOF | quanta captured, waiting for the FCS end
module enet_rx_pause_ctrl
   import enet_pkg::*;
#(
   parameter int PAUSE_W = 16
) (
   input  logic               rx_clk,
   input  logic               rst_n,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   input  logic               rx_sof,
   input  logic               rx_eof,
   input  logic               rx_crc_ok,
   input  logic [31:0]        palr,
   input  logic [15:0]        paur_u16,
   input  logic               quanta_tick,
   output logic               pause_active,
   output logic [PAUSE_W-1:0] pause_quanta,
   output logic               pause_rcvd,
   output logic               ctrl_frame
);

   parse_state_t state, state_nxt, base_state;
   logic [2:0]   cnt, cnt_nxt, base_cnt;
   logic         reject, reject_nxt, base_reject;
   logic         type_hi_ok, type_hi_ok_nxt;
   logic         type_ctrl, type_ctrl_nxt, base_type_ctrl;
   logic         quanta_done, quanta_done_nxt, base_quanta_done;
   logic [15:0]  quanta_hold, quanta_hold_nxt;
   logic         mc_miss, mc_miss_nxt, base_mc_miss;
   logic         da_bad;
   logic         accept;
   logic         ctrl_hit;

`ifdef ENET_RX_PAUSE_UNICAST_EN
   logic         st_miss, st_miss_nxt, base_st_miss;
`else
   logic         unused_station;
   assign unused_station = ^{palr, paur_u16};
`endif

   // Next-state parse of the current byte; a sof byte is always DA byte 0 of a fresh frame.
   always_comb begin
      base_state       = state;
      base_cnt         = cnt;
      base_reject      = reject;
      base_type_ctrl   = type_ctrl;
      base_quanta_done = quanta_done;
      base_mc_miss     = mc_miss;
`ifdef ENET_RX_PAUSE_UNICAST_EN
      base_st_miss     = st_miss;
`endif
      if (rx_valid && rx_sof) begin
         base_state       = ST_DA;
         base_cnt         = 3'd0;
         base_reject      = 1'b0;
         base_type_ctrl   = 1'b0;
         base_quanta_done = 1'b0;
         base_mc_miss     = 1'b0;
`ifdef ENET_RX_PAUSE_UNICAST_EN
         base_st_miss     = 1'b0;
`endif
      end

      state_nxt       = state;
      cnt_nxt         = cnt;
      reject_nxt      = reject;
      type_hi_ok_nxt  = type_hi_ok;
      type_ctrl_nxt   = type_ctrl;
      quanta_done_nxt = quanta_done;
      quanta_hold_nxt = quanta_hold;
      mc_miss_nxt     = mc_miss;
`ifdef ENET_RX_PAUSE_UNICAST_EN
      st_miss_nxt     = st_miss;
`endif
      da_bad          = 1'b0;
      accept          = 1'b0;
      ctrl_hit        = 1'b0;

      if (rx_valid) begin
         state_nxt       = base_state;
         cnt_nxt         = base_cnt;
         reject_nxt      = base_reject;
         type_ctrl_nxt   = base_type_ctrl;
         quanta_done_nxt = base_quanta_done;
         mc_miss_nxt     = base_mc_miss;
`ifdef ENET_RX_PAUSE_UNICAST_EN
         st_miss_nxt     = base_st_miss;
`endif
         case (base_state)
            ST_DA: begin
               mc_miss_nxt = base_mc_miss | (rx_data != addr_byte(ENET_PAUSE_MCAST, base_cnt));
`ifdef ENET_RX_PAUSE_UNICAST_EN
               st_miss_nxt = base_st_miss | (rx_data != addr_byte({palr, paur_u16}, base_cnt));
               da_bad      = mc_miss_nxt & st_miss_nxt;
`else
               da_bad      = mc_miss_nxt;
`endif
               if (base_cnt == 3'd5) begin
                  if (da_bad) reject_nxt = 1'b1;
                  state_nxt = ST_SA;
                  cnt_nxt   = 3'd0;
               end else begin
                  cnt_nxt = base_cnt + 3'd1;
               end
            end
            ST_SA: begin
               if (base_cnt == 3'd5) begin
                  state_nxt = ST_TYPE;
                  cnt_nxt   = 3'd0;
               end else begin
                  cnt_nxt = base_cnt + 3'd1;
               end
            end
            ST_TYPE: begin
               if (!base_cnt[0]) begin
                  type_hi_ok_nxt = (rx_data == field_byte(ENET_TYPE_MAC_CTRL, 1'b0));
                  if (!type_hi_ok_nxt) reject_nxt = 1'b1;
                  cnt_nxt = 3'd1;
               end else begin
                  type_ctrl_nxt = type_hi_ok && (rx_data == field_byte(ENET_TYPE_MAC_CTRL, 1'b1));
                  if (rx_data != field_byte(ENET_TYPE_MAC_CTRL, 1'b1)) reject_nxt = 1'b1;
                  state_nxt = ST_OPC;
                  cnt_nxt   = 3'd0;
               end
            end
            ST_OPC: begin
               if (rx_data != field_byte(ENET_OPC_PAUSE, base_cnt[0])) reject_nxt = 1'b1;
               if (!base_cnt[0]) begin
                  cnt_nxt = 3'd1;
               end else begin
                  state_nxt = ST_QUANTA;
                  cnt_nxt   = 3'd0;
               end
            end
            ST_QUANTA: begin
               if (!base_cnt[0]) begin
                  quanta_hold_nxt[15:8] = rx_data;
                  cnt_nxt = 3'd1;
               end else begin
                  quanta_hold_nxt[7:0] = rx_data;
                  quanta_done_nxt      = 1'b1;
                  state_nxt            = ST_WAIT_EOF;
                  cnt_nxt              = 3'd0;
               end
            end
            ST_IDLE, ST_WAIT_EOF: ;
            default: state_nxt = ST_IDLE;
         endcase

         // The eof byte is parsed first, so a field finishing on it still counts.
         if (rx_eof && (base_state != ST_IDLE)) begin
            ctrl_hit  = type_ctrl_nxt;
            accept    = quanta_done_nxt && !reject_nxt && rx_crc_ok;
            state_nxt = ST_IDLE;
            cnt_nxt   = 3'd0;
         end
      end
   end

   // Parser registers and the one-cycle result pulses.
   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= 3'd0;
         reject      <= 1'b0;
         type_hi_ok  <= 1'b0;
         type_ctrl   <= 1'b0;
         quanta_done <= 1'b0;
         quanta_hold <= 16'h0000;
         mc_miss     <= 1'b0;
`ifdef ENET_RX_PAUSE_UNICAST_EN
         st_miss     <= 1'b0;
`endif
         pause_rcvd  <= 1'b0;
         ctrl_frame  <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         reject      <= reject_nxt;
         type_hi_ok  <= type_hi_ok_nxt;
         type_ctrl   <= type_ctrl_nxt;
         quanta_done <= quanta_done_nxt;
         quanta_hold <= quanta_hold_nxt;
         mc_miss     <= mc_miss_nxt;
`ifdef ENET_RX_PAUSE_UNICAST_EN
         st_miss     <= st_miss_nxt;
`endif
         pause_rcvd  <= accept;
         ctrl_frame  <= ctrl_hit;
      end
   end

   // Accepted quanta land in the timer on the same edge that raises pause_rcvd.
   enet_pause_timer #(
      .PAUSE_W (PAUSE_W)
   ) u_timer (
      .rx_clk   (rx_clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (PAUSE_W'(quanta_hold_nxt)),
      .tick     (quanta_tick),
      .count    (pause_quanta),
      .active   (pause_active)
   );

endmodule

// File: tb/tb_enet_rx_pause_ctrl.sv
// Bench for enet_rx_pause_ctrl: vector table, corner sequences and random frames
// checked every cycle against a frame-level reference model.
module tb_enet_rx_pause_ctrl;

   localparam logic [47:0] MCAST = 48'h0180C2000001;
`ifdef ENET_RX_PAUSE_UNICAST_EN
   localparam bit UNI = 1'b1;
`else
   localparam bit UNI = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   typedef struct {
      logic [47:0] da;
      logic [15:0] ty;
      logic [15:0] op;
      logic [15:0] q;
      int          len;
      bit          crc;
      int          exp_rcvd;
      int          exp_ctrl;
      logic [15:0] exp_q;
   } vec_t;

   logic        rx_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_sof = 1'b0;
   logic        rx_eof = 1'b0;
   logic        rx_crc_ok = 1'b0;
   logic [31:0] palr;
   logic [15:0] paur_u16;
   logic        quanta_tick = 1'b0;
   logic        pause_active;
   logic [15:0] pause_quanta;
   logic        pause_rcvd;
   logic        ctrl_frame;

   logic [47:0] station = 48'h021122334455;

   int total = 0;
   int bad = 0;

   logic [7:0]  m_bytes[$];
   bit          m_in_frame = 1'b0;
   logic [15:0] m_timer = 16'h0;
   bit          m_rcvd = 1'b0;
   bit          m_ctrl = 1'b0;
   int          seen_rcvd, seen_ctrl;

   vec_t vt[10];

   always #5 rx_clk = ~rx_clk;

   enet_rx_pause_ctrl #(.PAUSE_W(16)) dut (
      .rx_clk       (rx_clk),
      .rst_n        (rst_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_sof       (rx_sof),
      .rx_eof       (rx_eof),
      .rx_crc_ok    (rx_crc_ok),
      .palr         (palr),
      .paur_u16     (paur_u16),
      .quanta_tick  (quanta_tick),
      .pause_active (pause_active),
      .pause_quanta (pause_quanta),
      .pause_rcvd   (pause_rcvd),
      .ctrl_frame   (ctrl_frame)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Whole-frame verdict from the bytes seen since the last sof.
   function automatic void model_eval(input bit crc, output bit acc, output bit ctl, output logic [15:0] qv);
      int n;
      logic [47:0] da;
      logic [15:0] ty, op;
      n = m_bytes.size();
      acc = 1'b0; ctl = 1'b0; qv = 16'h0;
      if (n >= 14) begin
         ty  = {m_bytes[12], m_bytes[13]};
         ctl = (ty == 16'h8808);
      end
      if (n >= 18) begin
         da  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3], m_bytes[4], m_bytes[5]};
         op  = {m_bytes[14], m_bytes[15]};
         qv  = {m_bytes[16], m_bytes[17]};
         acc = ctl && (op == 16'h0001) && crc && ((da == MCAST) || (UNI && (da == station)));
      end
   endfunction

   // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
   task automatic cyc(input bit v, input logic [7:0] d, input bit sof, input bit eof,
                      input bit crc, input bit tk);
      bit acc, ctl;
      logic [15:0] qv;
      rx_valid = v; rx_data = d; rx_sof = sof; rx_eof = eof; rx_crc_ok = crc; quanta_tick = tk;
      acc = 1'b0; ctl = 1'b0; qv = 16'h0;
      if (v) begin
         if (sof) begin
            m_bytes.delete();
            m_in_frame = 1'b1;
         end
         if (m_in_frame) begin
            m_bytes.push_back(d);
            if (eof) begin
               model_eval(crc, acc, ctl, qv);
               m_in_frame = 1'b0;
            end
         end
      end
      @(posedge rx_clk);
      if (acc) m_timer = qv;
      else if (tk && (m_timer != 16'h0)) m_timer = m_timer - 16'h1;
      m_rcvd = acc;
      m_ctrl = ctl;
      #1;
      chk("pause_rcvd", {31'h0, pause_rcvd}, {31'h0, m_rcvd});
      chk("ctrl_frame", {31'h0, ctrl_frame}, {31'h0, m_ctrl});
      chk("pause_quanta", {16'h0, pause_quanta}, {16'h0, m_timer});
      chk("pause_active", {31'h0, pause_active}, {31'h0, (m_timer != 16'h0)});
      seen_rcvd += int'(pause_rcvd);
      seen_ctrl += int'(ctrl_frame);
   endtask

   task automatic idle(input int n, input int tick_pct);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(99) < tick_pct));
   endtask

   task automatic send(input bq_t fb, input bit crc, input int gap_pct, input int tick_pct,
                       input bit with_eof, input bit tick_last);
      int last;
      last = fb.size() - 1;
      for (int i = 0; i <= last; i++) begin
         for (int g = 0; g < 3 && ($urandom_range(99) < gap_pct); g++) idle(1, tick_pct);
         cyc(1'b1, fb[i], (i == 0), with_eof && (i == last), crc,
             (i == last) ? tick_last : ($urandom_range(99) < tick_pct));
      end
   endtask

   function automatic bq_t build(input logic [47:0] da, input logic [15:0] ty,
                                 input logic [15:0] op, input logic [15:0] q, input int len);
      bq_t b;
      logic [47:0] sh;
      for (int i = 0; i < len; i++) begin
         if (i < 6) begin
            sh = da >> (8 * (5 - i));
            b.push_back(sh[7:0]);
         end else if (i < 12) b.push_back(8'($urandom));
         else if (i == 12)   b.push_back(ty[15:8]);
         else if (i == 13)   b.push_back(ty[7:0]);
         else if (i == 14)   b.push_back(op[15:8]);
         else if (i == 15)   b.push_back(op[7:0]);
         else if (i == 16)   b.push_back(q[15:8]);
         else if (i == 17)   b.push_back(q[7:0]);
         else                b.push_back(8'($urandom));
      end
      return b;
   endfunction

   task automatic frame_chk(input string nm, input int er, input int ec, input logic [15:0] eq);
      chk({nm, "_rcvd"}, seen_rcvd, er);
      chk({nm, "_ctrl"}, seen_ctrl, ec);
      chk({nm, "_quanta"}, {16'h0, pause_quanta}, {16'h0, eq});
      chk({nm, "_active"}, {31'h0, pause_active}, {31'h0, (eq != 16'h0)});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bq_t fb, part;
      logic [47:0] da;
      palr     = station[47:16];
      paur_u16 = station[15:0];

      vt[0] = '{MCAST,   16'h8808, 16'h0001, 16'h0003, 24, 1'b1, 1, 1, 16'h0003};
      vt[1] = '{MCAST,   16'h8808, 16'h0001, 16'h0009, 24, 1'b0, 0, 1, 16'h0003};
      vt[2] = '{MCAST,   16'h0800, 16'h0001, 16'h0007, 24, 1'b1, 0, 0, 16'h0003};
      vt[3] = '{MCAST,   16'h8808, 16'h0002, 16'h0007, 24, 1'b1, 0, 1, 16'h0003};
      vt[4] = '{MCAST,   16'h8808, 16'h0001, 16'h0007, 16, 1'b1, 0, 1, 16'h0003};
      vt[5] = '{MCAST,   16'h8808, 16'h0001, 16'h0007, 12, 1'b1, 0, 0, 16'h0003};
      vt[6] = '{48'h0180C2000002, 16'h8808, 16'h0001, 16'h0007, 24, 1'b1, 0, 1, 16'h0003};
      vt[7] = '{station, 16'h8808, 16'h0001, 16'h0005, 24, 1'b1, UNI ? 1 : 0, 1,
                UNI ? 16'h0005 : 16'h0003};
      vt[8] = '{MCAST,   16'h8808, 16'h0001, 16'h0010, 18, 1'b1, 1, 1, 16'h0010};
      vt[9] = '{MCAST,   16'h8808, 16'h0001, 16'h0000, 20, 1'b1, 1, 1, 16'h0000};

      // reset state
      #12;
      chk("rst_active", {31'h0, pause_active}, 32'h0);
      chk("rst_quanta", {16'h0, pause_quanta}, 32'h0);
      chk("rst_rcvd", {31'h0, pause_rcvd}, 32'h0);
      chk("rst_ctrl", {31'h0, ctrl_frame}, 32'h0);
      @(posedge rx_clk); #1;
      rst_n = 1'b1;
      idle(2, 0);

      // vector table, no ticks so the timer value is deterministic
      for (int r = 0; r < 10; r++) begin
         seen_rcvd = 0; seen_ctrl = 0;
         send(build(vt[r].da, vt[r].ty, vt[r].op, vt[r].q, vt[r].len), vt[r].crc, 20, 0, 1'b1, 1'b0);
         idle(1, 0);
         frame_chk($sformatf("tbl%0d", r), vt[r].exp_rcvd, vt[r].exp_ctrl, vt[r].exp_q);
      end

      // quanta 3 then three ticks: active falls with the third
      send(build(MCAST, 16'h8808, 16'h0001, 16'h0003, 20), 1'b1, 0, 0, 1'b1, 1'b0);
      chk("q3_loaded", {16'h0, pause_quanta}, 32'h3);
      for (int k = 1; k <= 3; k++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
         chk($sformatf("q3_tick%0d_active", k), {31'h0, pause_active}, (k < 3) ? 32'h1 : 32'h0);
      end

      // timer at 2, overwrite with 0x10 while a tick coincides, then clear with quanta 0
      send(build(MCAST, 16'h8808, 16'h0001, 16'h0002, 20), 1'b1, 0, 0, 1'b1, 1'b0);
      chk("ovr_pre", {16'h0, pause_quanta}, 32'h2);
      send(build(MCAST, 16'h8808, 16'h0001, 16'h0010, 20), 1'b1, 0, 0, 1'b1, 1'b1);
      chk("ovr_load_wins", {16'h0, pause_quanta}, 32'h10);
      send(build(MCAST, 16'h8808, 16'h0001, 16'h0000, 20), 1'b1, 0, 0, 1'b1, 1'b0);
      chk("zero_clears", {31'h0, pause_active}, 32'h0);

      // restart by sof mid-frame, after a rejected partial DA
      part = build(48'h0180C2000009, 16'h8808, 16'h0001, 16'h0044, 15);
      send(part, 1'b1, 10, 0, 1'b0, 1'b0);
      seen_rcvd = 0; seen_ctrl = 0;
      send(build(MCAST, 16'h8808, 16'h0001, 16'h0021, 22), 1'b1, 10, 0, 1'b1, 1'b0);
      idle(1, 0);
      frame_chk("restart", 1, 1, 16'h0021);

      // reset mid-frame with the timer loaded
      send(build(MCAST, 16'h8808, 16'h0001, 16'h00FF, 20), 1'b1, 0, 0, 1'b1, 1'b0);
      chk("pre_rst", {16'h0, pause_quanta}, 32'hFF);
      fb = build(MCAST, 16'h8808, 16'h0001, 16'h0033, 20);
      for (int i = 0; i < 9; i++) cyc(1'b1, fb[i], (i == 0), 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mrst_active", {31'h0, pause_active}, 32'h0);
      chk("mrst_quanta", {16'h0, pause_quanta}, 32'h0);
      chk("mrst_rcvd", {31'h0, pause_rcvd}, 32'h0);
      chk("mrst_ctrl", {31'h0, ctrl_frame}, 32'h0);
      m_bytes.delete(); m_in_frame = 1'b0; m_timer = 16'h0; m_rcvd = 1'b0; m_ctrl = 1'b0;
      @(posedge rx_clk); @(posedge rx_clk); #1;
      rst_n = 1'b1;
      for (int i = 9; i < 20; i++) cyc(1'b1, fb[i], 1'b0, (i == 19), 1'b1, 1'b0);
      chk("tail_ignored", {16'h0, pause_quanta}, 32'h0);
      seen_rcvd = 0; seen_ctrl = 0;
      send(build(MCAST, 16'h8808, 16'h0001, 16'h000A, 20), 1'b1, 0, 0, 1'b1, 1'b0);
      idle(1, 0);
      frame_chk("post_rst", 1, 1, 16'h000A);

      // random frames against the model
      for (int f = 0; f < 200; f++) begin
         int sel;
         logic [15:0] ty, op;
         sel = $urandom_range(99);
         da  = (sel < 70) ? MCAST : (sel < 85) ? station : {$urandom, 16'($urandom)};
         ty  = ($urandom_range(9) != 0) ? 16'h8808 : 16'($urandom);
         op  = ($urandom_range(9) != 0) ? 16'h0001 : 16'($urandom);
         if ($urandom_range(9) == 0)
            send(build(da, ty, op, 16'($urandom), $urandom_range(1, 20)), 1'b1, 20, 30, 1'b0, 1'b0);
         fb = build(da, ty, op, 16'($urandom_range(0, 40)),
                    ($urandom_range(99) < 85) ? $urandom_range(18, 28) : $urandom_range(1, 17));
         send(fb, ($urandom_range(9) != 0), 20, 30, 1'b1, 1'($urandom));
         idle($urandom_range(0, 3), 30);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
